// File: rtl/token_avg_pool.sv
// Token average pool: sums NTOK signed tokens per frame, takes the floor mean, adds bias
// and saturates to DW bits. A frame-length mismatch raises a one-cycle error pulse.
module token_avg_pool #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NTOK = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  output logic          i_ready,
  input  logic [DW-1:0] bias,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_err
);

  localparam int unsigned LG = $clog2(NTOK);
  localparam int unsigned AW = DW + LG;
  localparam logic [LG-1:0] CntLast = LG'(NTOK - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [LG-1:0] cnt_q, cnt_d;
  logic [DW-1:0] o_data_q, o_data_d;
  logic          o_err_q, o_err_d;

  logic          accept;
  logic [AW-1:0] tok_ext;
  logic [AW-1:0] tot;
  logic [DW-1:0] mean;
  logic [DW:0]   sum;
  logic [DW-1:0] sat;

  assign i_ready = (state_q != StOut);
  assign o_valid = (state_q == StOut);
  assign o_data  = o_data_q;
  assign o_err   = o_err_q;

  // Datapath: the upper DW bits of the total are the arithmetic shift by LG (floor mean).
  always_comb begin
    accept  = i_valid && i_ready;
    tok_ext = {{LG{i_data[DW-1]}}, i_data};
    tot     = acc_q + tok_ext;
    mean    = tot[AW-1:LG];
    sum     = {mean[DW-1], mean} + {bias[DW-1], bias};
    if (sum[DW] != sum[DW-1]) begin
      sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat = sum[DW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    o_data_d = o_data_q;
    o_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (i_last) begin
            o_err_d = 1'b1;
          end else begin
            acc_d   = tok_ext;
            cnt_d   = LG'(1);
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (accept) begin
          if (cnt_q == CntLast) begin
            o_data_d = sat;
            o_err_d  = ~i_last;
            state_d  = StOut;
          end else if (i_last) begin
            o_err_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            acc_d = tot;
            cnt_d = cnt_q + LG'(1);
          end
        end
      end
      StOut: begin
        if (o_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      o_data_q <= '0;
      o_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      o_data_q <= o_data_d;
      o_err_q  <= o_err_d;
    end
  end

endmodule
